// File: rtl/sort_unloader.sv
// sort_unloader: snapshots the sorter's eight ranked outputs on the rising
// edge of done and streams them one per valid/ready transfer.
// Optional build macro SORT_UNLOADER_DESCEND_EN: stream highest-first.
module sort_unloader #(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [W-1:0] LT,
    input  logic [W-1:0] LO,
    input  logic [W-1:0] LM,
    input  logic [W-1:0] ME,
    input  logic [W-1:0] MH,
    input  logic [W-1:0] HI,
    input  logic [W-1:0] HR,
    input  logic [W-1:0] HT,
    input  logic         ready,
    output logic [W-1:0] OUT,
    output logic         valid,
    output logic         last,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t              state_q, state_d;
    logic                done_q;
    logic [N-1:0][W-1:0] sbuf_q, sbuf_d;
    logic [2:0]          idx_q, idx_d;
    logic [W-1:0]        out_q, out_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [N-1:0][W-1:0] snap;
    logic                start;
    logic                xfer;

    // Slot 0 is streamed first; the macro only changes the load order.
`ifdef SORT_UNLOADER_DESCEND_EN
    assign snap = {LT, LO, LM, ME, MH, HI, HR, HT};
`else
    assign snap = {HT, HR, HI, MH, ME, LM, LO, LT};
`endif

    assign start = done & ~done_q;
    assign xfer  = valid_q & ready;

    // Next-state and registered-output values; everything holds by default.
    always_comb begin
        state_d = state_q;
        sbuf_d  = sbuf_q;
        idx_d   = idx_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sbuf_d  = snap;
                    idx_d   = 3'd0;
                    out_d   = snap[0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        out_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = done ? HOLD : IDLE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        out_d  = sbuf_q[idx_d];
                        last_d = (idx_d == 3'd7);
                    end
                end
            end
            HOLD: begin
                // One stream per done assertion: wait for done to fall.
                if (!done) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                out_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers; reset aborts any stream at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            sbuf_q  <= '0;
            idx_q   <= 3'd0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done;
            sbuf_q  <= sbuf_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign OUT   = out_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = valid_q;

endmodule

// File: tb/tb_sort_unloader.sv
// Directed bench for sort_unloader: basic, backpressure, level done,
// re-arm, mid-stream reset and done-high-out-of-reset.
module tb_sort_unloader;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [3:0] LT, LO, LM, ME, MH, HI, HR, HT;
    logic       ready;
    logic [3:0] OUT;
    logic       valid, last, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sort_unloader #(.W(4), .N(8)) dut (
        .clk(clk), .rst(rst), .done(done),
        .LT(LT), .LO(LO), .LM(LM), .ME(ME), .MH(MH), .HI(HI), .HR(HR), .HT(HT),
        .ready(ready), .OUT(OUT), .valid(valid), .last(last), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Nibble k of v is the k-th value of the stream in ascending build.
    function automatic logic [31:0] order(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef SORT_UNLOADER_DESCEND_EN
        for (int k = 0; k < 8; k++) r[4*k +: 4] = v[4*(7-k) +: 4];
`endif
        return r;
    endfunction

    task automatic load(input logic [31:0] v);
        LT = v[3:0];   LO = v[7:4];   LM = v[11:8];  ME = v[15:12];
        MH = v[19:16]; HI = v[23:20]; HR = v[27:24]; HT = v[31:28];
    endtask

    // Called at the negedge where the first value should be on the bus.
    // mode 0: ready always high; mode 1: ready high every third cycle.
    task automatic run_stream(input string nm, input logic [31:0] v, input int mode);
        logic [31:0] e;
        logic [3:0]  ev;
        int k, cyc;
        e = order(v);
        k = 0; cyc = 0;
        while (k < 8 && cyc < 100) begin
            ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            ev = e[4*k +: 4];
            chk({nm, " valid"}, 32'(valid), 32'd1);
            chk({nm, " OUT"},   32'(OUT),   32'(ev));
            chk({nm, " last"},  32'(last),  32'(k == 7));
            chk({nm, " busy"},  32'(busy),  32'd1);
            if (ready) k++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " completed"}, 32'(k), 32'd8);
        chk({nm, " valid after"}, 32'(valid), 32'd0);
        chk({nm, " last after"},  32'(last),  32'd0);
        chk({nm, " OUT after"},   32'(OUT),   32'd0);
    endtask

    task automatic idle_for(input string nm, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk({nm, " stays idle"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; ready = 1'b0;
        load(32'h0);
        repeat (2) @(negedge clk);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset OUT",   32'(OUT),   32'd0);
        chk("reset last",  32'(last),  32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        rst = 1'b0;
        idle_for("post reset", 3);

        // Basic stream: one-cycle done pulse, ready high.
        load(32'hFC985321);
        done = 1'b1; ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        run_stream("basic", 32'hFC985321, 0);
        idle_for("basic tail", 3);

        // Backpressure.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        run_stream("bp", 32'hFC985321, 1);
        idle_for("bp tail", 3);

        // Level done with input change after capture.
        ready = 1'b1;
        done = 1'b1;
        @(negedge clk);
        LT = 4'h7;
        run_stream("level", 32'hFC985321, 0);
        idle_for("level hold", 20);
        chk("level in HOLD", 32'(dut.state_q), 32'd2);
        done = 1'b0;
        idle_for("level drop", 3);

        // Re-arm with new values including duplicates.
        load(32'hEBA44400);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        run_stream("rearm", 32'hEBA44400, 0);
        idle_for("rearm tail", 2);

        // Reset after the third transfer.
        load(32'hFC985321);
        done = 1'b1; ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst pre valid", 32'(valid), 32'd1);
        chk("midrst pre OUT",   32'(OUT),   32'(order(32'hFC985321) >> 12) & 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("midrst valid", 32'(valid), 32'd0);
        chk("midrst OUT",   32'(OUT),   32'd0);
        chk("midrst last",  32'(last),  32'd0);
        chk("midrst busy",  32'(busy),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_for("midrst release", 6);

        // done already high on the first edge after reset.
        rst = 1'b1; done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_stream("done at reset", 32'hFC985321, 0);
        done = 1'b0;
        idle_for("final", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
